// File: rtl/spm_job_sequencer_if.sv
// Host/SPM bundle for the scratchpad job sequencer.
// master = host/SPM side, slave = sequencer side.
interface spm_job_sequencer_if #(
    parameter int JOB_DEPTH = 4,
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 8
);
    localparam int LW = $clog2(JOB_DEPTH) + 1;

    logic                 job_wr_en;
    logic [31:0]          job_wr_data;
    logic                 job_full;
    logic [LW-1:0]        job_level;
    logic                 run;
    logic                 abort;
    logic [TIMEOUT_W-1:0] timeout_limit;
    logic [31:0]          spm_csr_out;
    logic [31:0]          spm_status_in;
    logic                 busy;
    logic                 job_done;
    logic                 err_timeout;
    logic [CNT_W-1:0]     jobs_completed;

    modport master (
        output job_wr_en, job_wr_data, run, abort,
        output timeout_limit, spm_status_in,
        input  job_full, job_level, spm_csr_out,
        input  busy, job_done, err_timeout, jobs_completed
    );

    modport slave (
        input  job_wr_en, job_wr_data, run, abort,
        input  timeout_limit, spm_status_in,
        output job_full, job_level, spm_csr_out,
        output busy, job_done, err_timeout, jobs_completed
    );
endinterface

// File: rtl/spm_job_sequencer.sv
// Scratchpad job sequencer: queues host descriptors, drives each as the
// SPM config word and waits for ingress / write-back completion.
// Ports: clk, rst (sync, active-high), bus (spm_job_sequencer_if.slave):
//   job push side (job_wr_en/data, job_full, job_level), control
//   (run, abort, timeout_limit), SPM side (spm_csr_out, spm_status_in)
//   and status (busy, job_done, err_timeout, jobs_completed).
module spm_job_sequencer #(
    parameter int JOB_DEPTH = 4,
    parameter int BANK_SIZE = 512,
    parameter int TIMEOUT_W = 16,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    spm_job_sequencer_if.slave bus
);
    localparam int NW = $clog2(BANK_SIZE);
    localparam int AW = $clog2(JOB_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [2:0] {
        IDLE, ISSUE, INGRESS, EGRESS, DONE, ERR
    } state_t;

    state_t               state;
    logic [31:0]          mem [JOB_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;
    logic [LW-1:0]        level_nxt;
    logic                 full;
    logic [31:0]          cur_job;
    logic [31:0]          csr;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;
    logic [CNT_W-1:0]     n_done;
    logic [TIMEOUT_W-1:0] wd;
    logic                 kfin_q;
    logic                 ifin_q;

    logic kfin_rise;
    logic ifin_rise;
    logic phase_fin;
    logic expire;
    logic has_in;
    logic need_wb;
    logic pop;
    logic push;
    logic unused_status;

    // Only rising edges count, so a fin left high by the previous
    // job cannot complete the current phase.
    assign kfin_rise = bus.spm_status_in[0] & ~kfin_q;
    assign ifin_rise = bus.spm_status_in[1] & ~ifin_q;
    assign phase_fin = (state == INGRESS) ? ifin_rise : kfin_rise;
    assign unused_status = ^bus.spm_status_in[31:2];

    assign has_in  = |cur_job[8 +: NW];
    assign need_wb = cur_job[2] & (|cur_job[8+NW +: NW]);

    assign expire = (bus.timeout_limit != '0) &&
                    (wd == bus.timeout_limit - TIMEOUT_W'(1));

    assign pop  = (state == IDLE) & bus.run &
                  (level != '0) & ~bus.abort;
    // A pop in the same cycle frees a slot, so a push while full is
    // still accepted then.
    assign push = bus.job_wr_en & (~full | pop) & ~bus.abort;

    always_comb begin
        level_nxt = level;
        if (push & ~pop)
            level_nxt = level + LW'(1);
        else if (pop & ~push)
            level_nxt = level - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.job_wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            full  <= (level_nxt == LW'(JOB_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cur_job <= '0;
            csr     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            n_done  <= '0;
            wd      <= '0;
            kfin_q  <= 1'b0;
            ifin_q  <= 1'b0;
        end else begin
            kfin_q <= bus.spm_status_in[0];
            ifin_q <= bus.spm_status_in[1];
            done_q <= 1'b0;
            if (bus.abort) begin
                state   <= IDLE;
                cur_job <= '0;
                csr     <= '0;
                busy_q  <= 1'b0;
                err_q   <= 1'b0;
                wd      <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        csr <= '0;
                        if (pop) begin
                            cur_job <= mem[rd_ptr];
                            busy_q  <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        csr <= cur_job;
                        wd  <= '0;
                        if (has_in)
                            state <= INGRESS;
                        else if (need_wb)
                            state <= EGRESS;
                        else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            n_done <= n_done + CNT_W'(1);
                        end
                    end
                    INGRESS, EGRESS: begin
                        // A fin event beats a same-cycle expiry.
                        if (phase_fin) begin
                            wd <= '0;
                            if (state == INGRESS && need_wb)
                                state <= EGRESS;
                            else begin
                                state  <= DONE;
                                done_q <= 1'b1;
                                n_done <= n_done + CNT_W'(1);
                            end
                        end else if (expire) begin
                            state <= ERR;
                            csr   <= '0;
                            err_q <= 1'b1;
                        end else
                            wd <= wd + TIMEOUT_W'(1);
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    ERR: begin
                        csr <= '0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.job_full       = full;
    assign bus.job_level      = level;
    assign bus.spm_csr_out    = csr;
    assign bus.busy           = busy_q;
    assign bus.job_done       = done_q;
    assign bus.err_timeout    = err_q;
    assign bus.jobs_completed = n_done;
endmodule

// File: tb/tb_spm_job_sequencer.sv
// Self-checking bench for spm_job_sequencer: vector table, corner
// sequences and randomized jobs against a queue-based reference model.
`timescale 1ns/1ps
module tb_spm_job_sequencer;
    localparam int JD = 4;
    localparam int TW = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    logic ifin;
    logic kfin;

    always #5 clk = ~clk;

    spm_job_sequencer_if #(.JOB_DEPTH(JD), .TIMEOUT_W(TW), .CNT_W(CW)) bus ();

    spm_job_sequencer #(
        .JOB_DEPTH(JD), .BANK_SIZE(512), .TIMEOUT_W(TW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    assign bus.spm_status_in = {30'd0, ifin, kfin};

    int errs   = 0;
    int checks = 0;
    int ncomp  = 0;

    typedef struct {
        logic [31:0] d;
        int          d1;
        int          d2;
        int          lat;
    } vec_t;

    vec_t        tv [7];
    logic [31:0] mq [$];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d);
        bus.job_wr_en   = 1'b1;
        bus.job_wr_data = d;
        step();
        bus.job_wr_en = 1'b0;
    endtask

    function automatic logic [31:0] mkd(input int wb, input int pid,
                                        input int nin, input int nout);
        logic [31:0] d;
        d        = '0;
        d[0]     = 1'b1;
        d[2]     = wb[0];
        d[7:4]   = pid[3:0];
        d[16:8]  = nin[8:0];
        d[25:17] = nout[8:0];
        return d;
    endfunction

    function automatic logic [31:0] cnt_exp();
        return 32'(ncomp % 256);
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        ifin              = 1'b0;
        kfin              = 1'b0;
        bus.job_wr_en     = 1'b0;
        bus.job_wr_data   = '0;
        bus.run           = 1'b0;
        bus.abort         = 1'b0;
        bus.timeout_limit = '0;

        tv[0] = '{mkd(0, 1, 0, 0), -1, -1, 2};
        tv[1] = '{32'h0000_0A45, 20, -1, 23};
        tv[2] = '{mkd(1, 2, 0, 5), -1, 3, 6};
        tv[3] = '{mkd(1, 3, 4, 4), 2, 1, 7};
        tv[4] = '{mkd(0, 5, 3, 7), 0, -1, 3};
        tv[5] = '{mkd(1, 6, 0, 0), -1, -1, 2};
        tv[6] = '{mkd(1, 7, 0, 1), -1, 0, 3};

        repeat (3) step();
        rst = 1'b0;
        chk("rst_csr", bus.spm_csr_out, 0);
        chk("rst_full", bus.job_full, 0);
        chk("rst_level", bus.job_level, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.job_done, 0);
        chk("rst_err", bus.err_timeout, 0);
        chk("rst_cnt", bus.jobs_completed, 0);

        // Table: one job each, fixed fin schedule, expected latency
        // in cycles from the run-high cycle to the job_done cycle.
        foreach (tv[i]) begin
            int lat;
            push(tv[i].d);
            bus.run = 1'b1;
            lat = -1;
            for (int c = 1; c <= 60 && lat < 0; c++) begin
                step();
                if (c == 1)
                    chk($sformatf("v%0d_busy", i), bus.busy, 1);
                if (c == 2)
                    chk($sformatf("v%0d_csr", i), bus.spm_csr_out, tv[i].d);
                if (bus.job_done)
                    lat = c;
                ifin = (tv[i].d1 >= 0) && (c == 2 + tv[i].d1);
                if (tv[i].d1 >= 0)
                    kfin = (tv[i].d2 >= 0) && (c == 3 + tv[i].d1 + tv[i].d2);
                else
                    kfin = (tv[i].d2 >= 0) && (c == 2 + tv[i].d2);
            end
            ifin = 1'b0;
            kfin = 1'b0;
            bus.run = 1'b0;
            ncomp++;
            chk($sformatf("v%0d_lat", i), lat, tv[i].lat);
            chk($sformatf("v%0d_cnt", i), bus.jobs_completed, cnt_exp());
            step();
            chk($sformatf("v%0d_pulse", i), bus.job_done, 0);
            step();
            chk($sformatf("v%0d_csr0", i), bus.spm_csr_out, 0);
            chk($sformatf("v%0d_idle", i), bus.busy, 0);
        end

        // Stale kernel_fin: high before issue must not finish EGRESS.
        begin
            logic seen;
            kfin = 1'b1;
            step();
            step();
            push(mkd(1, 8, 4, 4));
            bus.run = 1'b1;
            seen = 1'b0;
            for (int c = 1; c <= 8; c++) begin
                step();
                seen |= bus.job_done;
                ifin = (c == 2);
            end
            chk("stale_no_done", seen, 0);
            chk("stale_busy", bus.busy, 1);
            kfin = 1'b0;
            step();
            kfin = 1'b1;
            step();
            chk("stale_done", bus.job_done, 1);
            kfin = 1'b0;
            bus.run = 1'b0;
            ncomp++;
            chk("stale_cnt", bus.jobs_completed, cnt_exp());
            step();
            step();
        end

        // Fill: 5 pushes into a 4-deep queue, 5th dropped, FIFO order.
        begin
            int ndone;
            logic [31:0] prev;
            exp_q.delete();
            got_q.delete();
            for (int i = 1; i <= 5; i++) begin
                push(mkd(0, i, 0, 0));
                if (i <= JD)
                    exp_q.push_back(mkd(0, i, 0, 0));
                chk($sformatf("fill_lvl%0d", i), bus.job_level,
                    (i < JD) ? i : JD);
                chk($sformatf("fill_full%0d", i), bus.job_full, i >= JD);
            end
            bus.run = 1'b1;
            ndone = 0;
            prev = '0;
            for (int c = 0; c < 40; c++) begin
                step();
                if (bus.spm_csr_out != prev && bus.spm_csr_out != 0)
                    got_q.push_back(bus.spm_csr_out);
                prev = bus.spm_csr_out;
                ndone += int'(bus.job_done);
            end
            bus.run = 1'b0;
            chk("fill_ndone", ndone, JD);
            chk("fill_nseen", got_q.size(), JD);
            foreach (exp_q[k])
                if (k < got_q.size())
                    chk($sformatf("fill_ord%0d", k), got_q[k], exp_q[k]);
            ncomp += JD;
            chk("fill_cnt", bus.jobs_completed, cnt_exp());
            chk("fill_lvl0", bus.job_level, 0);
        end

        // Fin rise in the same cycle as watchdog expiry: fin wins.
        bus.timeout_limit = 16'd8;
        push(mkd(0, 9, 5, 0));
        bus.run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 10) begin
                chk("race_done", bus.job_done, 1);
                chk("race_err", bus.err_timeout, 0);
            end
            ifin = (c == 9);
        end
        ifin = 1'b0;
        bus.run = 1'b0;
        ncomp++;
        chk("race_cnt", bus.jobs_completed, cnt_exp());
        chk("race_err_late", bus.err_timeout, 0);

        // Watchdog expiry 8 cycles after INGRESS entry, then abort.
        push(mkd(0, 10, 5, 0));
        bus.run = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 9)
                chk("wd_err_early", bus.err_timeout, 0);
        end
        chk("wd_err", bus.err_timeout, 1);
        chk("wd_csr", bus.spm_csr_out, 0);
        chk("wd_busy", bus.busy, 1);
        push(mkd(0, 11, 0, 0));
        chk("wd_keep_lvl", bus.job_level, 1);
        chk("wd_sticky", bus.err_timeout, 1);
        bus.abort       = 1'b1;
        bus.job_wr_en   = 1'b1;
        bus.job_wr_data = mkd(0, 12, 0, 0);
        step();
        bus.abort     = 1'b0;
        bus.job_wr_en = 1'b0;
        chk("ab_lvl", bus.job_level, 0);
        chk("ab_err", bus.err_timeout, 0);
        chk("ab_busy", bus.busy, 0);
        chk("ab_csr", bus.spm_csr_out, 0);
        chk("ab_cnt", bus.jobs_completed, cnt_exp());
        step();
        step();
        chk("ab_stay_idle", bus.busy, 0);
        bus.run = 1'b0;
        bus.timeout_limit = '0;

        // Reset in the middle of an EGRESS wait.
        push(mkd(1, 13, 0, 3));
        bus.run = 1'b1;
        step();
        step();
        step();
        push(mkd(0, 14, 0, 0));
        chk("mid_busy", bus.busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.run = 1'b0;
        ncomp = 0;
        chk("mid_csr", bus.spm_csr_out, 0);
        chk("mid_full", bus.job_full, 0);
        chk("mid_lvl", bus.job_level, 0);
        chk("mid_busy0", bus.busy, 0);
        chk("mid_done", bus.job_done, 0);
        chk("mid_err", bus.err_timeout, 0);
        chk("mid_cnt", bus.jobs_completed, 0);

        // Randomized batches against a queue model.
        for (int b = 0; b < 8; b++) begin
            int nb;
            mq.delete();
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                logic [31:0] d;
                d = mkd($urandom_range(0, 1), $urandom_range(0, 15),
                        $urandom_range(0, 3), $urandom_range(0, 2));
                d[1] = 1'($urandom_range(0, 1));
                d[3] = 1'($urandom_range(0, 1));
                push(d);
                if (mq.size() < JD)
                    mq.push_back(d);
                chk("rnd_lvl", bus.job_level, mq.size());
                chk("rnd_full", bus.job_full, mq.size() == JD);
            end
            bus.run = 1'b1;
            while (mq.size() > 0) begin
                int n;
                logic [31:0] d;
                d = mq.pop_front();
                n = 0;
                while (bus.spm_csr_out == 0 && n < 20) begin
                    step();
                    n++;
                end
                chk("rnd_issue_wait", n < 20, 1);
                chk("rnd_csr", bus.spm_csr_out, d);
                if (d[16:8] != 0) begin
                    repeat ($urandom_range(0, 3)) step();
                    ifin = 1'b1;
                    step();
                    ifin = 1'b0;
                end
                if (d[2] && d[25:17] != 0) begin
                    repeat ($urandom_range(0, 2)) step();
                    kfin = 1'b1;
                    step();
                    kfin = 1'b0;
                end
                n = 0;
                while (!bus.job_done && n < 20) begin
                    step();
                    n++;
                end
                chk("rnd_done_wait", n < 20, 1);
                ncomp++;
                chk("rnd_cnt", bus.jobs_completed, cnt_exp());
                n = 0;
                while (bus.spm_csr_out != 0 && n < 20) begin
                    step();
                    n++;
                end
                chk("rnd_clear_wait", n < 20, 1);
            end
            bus.run = 1'b0;
            step();
            step();
            chk("rnd_idle", bus.busy, 0);
            chk("rnd_err", bus.err_timeout, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/spm_job_sequencer.md
# spm_job_sequencer

Sequences back-to-back scratchpad jobs by programming the 32-bit SPM configuration word and waiting for its completion flags. Sits between the host CSR bank and the scratchpad top. Host pushes job descriptors into a small queue. The sequencer pops each descriptor, drives it as the SPM config word, then waits for ingress completion and (optionally) write-back completion before starting the next job, with a per-phase timeout watchdog.

## Interface
- JOB_DEPTH, 4, descriptor queue entries (power of two, ≥2)
- BANK_SIZE, 512, SPM bank words; field width NW = $clog2(BANK_SIZE) = 9
- TIMEOUT_W, 16, watchdog counter width
- CNT_W, 8, completed-job counter width

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- job_wr_en  in  1  push job_wr_data into queue; ignored when job_full
- job_wr_data  in  32  descriptor, SPM config layout: [0] ingress sel, [1] egress sel, [2] enable_wb, [3] pid_sel, [7:4] pkt_id, [8+NW-1:8] num_words_in, [8+2NW-1:8+NW] num_words_out, rest zero
- job_full  out  1  queue full
- job_level  out  $clog2(JOB_DEPTH)+1  queue occupancy
- run  in  1  level; when low, no new job is popped (current job completes)
- abort  in  1  pulse; flush queue, return to IDLE, clear error
- timeout_limit  in  TIMEOUT_W  cycles allowed per wait phase; 0 disables watchdog
- spm_csr_out  out  32  config word to SPM
- spm_status_in  in  32  SPM status; [0] kernel_fin, [1] pkt_ingress_fin
- busy  out  1  state ≠ IDLE
- job_done  out  1  one-cycle pulse per completed job
- err_timeout  out  1  sticky; set on watchdog expiry
- jobs_completed  out  CNT_W  completed-job count, wraps

## Operation
- Queue: synchronous FIFO, JOB_DEPTH entries, registered pointers. Simultaneous push and pop is legal when full (pop frees the slot in the same cycle, so the push is accepted). Push while full with no pop is dropped. Level stays unchanged on simultaneous push and pop.
- Fin edge detect: registered copies of kernel_fin and pkt_ingress_fin. Events are rising edges only (cur & ~prev). Stale high levels from a previous job never complete a phase.
- States:
  - IDLE: spm_csr_out = 0. If run & queue non-empty, pop head into cur_job and go ISSUE.
  - ISSUE: spm_csr_out = cur_job, held until the job leaves EGRESS. Clear the watchdog. Next state is INGRESS if num_words_in ≠ 0; else EGRESS if need_wb; else DONE.
  - INGRESS: wait for the ingress-fin rise. Then go EGRESS if need_wb, else DONE.
  - EGRESS: wait for the kernel-fin rise, then go DONE.
  - DONE: pulse job_done, jobs_completed += 1, go IDLE. spm_csr_out is cleared from IDLE.
  - ERR: spm_csr_out = 0, err_timeout = 1. Stay here until abort. Queue contents are retained until abort.
- need_wb = enable_wb & (num_words_out ≠ 0).
- Watchdog: counts cycles in INGRESS or EGRESS and resets on entry to each phase. When timeout_limit ≠ 0 and count == timeout_limit − 1 with no fin event that cycle, go ERR. If a fin event and expiry occur in the same cycle, the fin event wins.
- Abort: highest priority in every state. Next cycle: IDLE, queue empty, cur_job = 0, spm_csr_out = 0, err_timeout = 0. jobs_completed is not cleared. A job_wr_en in the same cycle as abort is dropped.
- Reset values: spm_csr_out 0, job_full 0, job_level 0, busy 0, job_done 0, err_timeout 0, jobs_completed 0, edge-detect registers 0, state IDLE.

## Timing
- All outputs are registered.
- Pop-to-config latency: queue non-empty & run at cycle N (IDLE) → ISSUE at N+1 → spm_csr_out = descriptor from N+2.
- A fin rise sampled at cycle M causes the state transition at M+1. job_done asserts one cycle after leaving the last wait phase (the DONE cycle).
- Minimum job period, zero-word job (no ingress, no wb): IDLE → ISSUE → DONE → IDLE = 3 cycles.
- Between jobs, spm_csr_out is 0 for at least one cycle (IDLE), so the SPM sees a config change per job.
- Watchdog expires exactly timeout_limit cycles after entering a phase.

## Test plan
- Single job 0x0000_0A45 (num_in = 10, enable_wb set... wb off, pkt_id 4), pulse pkt_ingress_fin 20 cycles after ISSUE → spm_csr_out = 0x0A45 for the duration, one job_done, jobs_completed = 1, no EGRESS visited.
- Job with enable_wb = 1, num_in = 4, num_out = 4, kernel_fin already high before issue → no completion until kernel_fin falls and re-rises after the ingress fin; then job_done.
- Push 5 jobs with JOB_DEPTH = 4, run low → job_full after 4, 5th dropped, job_level = 4. Raise run → exactly 4 job_done pulses, in push order.
- timeout_limit = 8, no fin ever → err_timeout set exactly 8 cycles after INGRESS entry, spm_csr_out = 0. Abort → IDLE, err cleared, job_level = 0.
- Fin rise on the same cycle as watchdog expiry → job completes, err_timeout stays 0. Reset mid-EGRESS → all outputs at reset values next cycle.
